// File: rtl/fp_fma_arbiter_pkg.sv
// Shared FPU definitions for the FMA arbiter slice.
// Holds the requester-id width, the in-flight tag record and a pointer helper.
// No logic of its own; latency and backpressure are defined by the users.
package fp_fma_arbiter_pkg;

  // Default requester count. ID_WIDTH is derived from it and bounds NUM_REQ
  // of any arbiter built on this package: NUM_REQ must not exceed 2**ID_WIDTH.
  localparam int unsigned FPU_NUM_REQ = 4;
  localparam int unsigned ID_WIDTH    = (FPU_NUM_REQ > 1) ? $clog2(FPU_NUM_REQ) : 1;

  // One in-flight operation: whether a real issue happened, and who owns it.
  typedef struct packed {
    logic                vld;
    logic [ID_WIDTH-1:0] id;
  } fma_tag_t;

  // Round-robin successor of a requester index, wrapping at n.
  function automatic logic [ID_WIDTH-1:0] rr_next(input logic [ID_WIDTH-1:0] idx,
                                                  input int unsigned         n);
    return ID_WIDTH'((32'(idx) + 32'd1) % n);
  endfunction

endpackage

// File: rtl/fp_fma_arbiter_rr_arb.sv
// Round-robin arbiter: pointer register plus combinational first-hit search.
// Latency: grant is combinational in the request cycle; pointer moves on the next edge.
// Backpressure: en_i low suppresses every grant and freezes the pointer.
//
// Ports:
//   clk_i, rst_ni : clock, async active-low reset (pointer returns to 0)
//   req_i         : request vector
//   en_i          : downstream can accept an operation this cycle
//   gnt_o         : one-hot grant, all-zero when nothing wins
//   idx_o         : index of the winner (0 when no grant)
module rr_arb_tree_lite
  import fp_fma_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ = FPU_NUM_REQ
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic [NUM_REQ-1:0]  req_i,
  input  logic                en_i,
  output logic [NUM_REQ-1:0]  gnt_o,
  output logic [ID_WIDTH-1:0] idx_o
);

  logic [ID_WIDTH-1:0] rr_q;
  logic [ID_WIDTH-1:0] rr_d;
  logic [ID_WIDTH-1:0] cand;
  logic                found;

  // Walk NUM_REQ slots starting at rr_q; the first asserted request wins.
  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    cand  = '0;
    found = 1'b0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      cand = ID_WIDTH'((32'(rr_q) + k) % NUM_REQ);
      if (en_i && !found && req_i[cand]) begin
        found       = 1'b1;
        gnt_o[cand] = 1'b1;
        idx_o       = cand;
      end
    end
  end

  // The winner drops to lowest priority next cycle; idle cycles keep the pointer.
  always_comb begin
    rr_d = rr_q;
    if (found) begin
      rr_d = rr_next(idx_o, NUM_REQ);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_q <= '0;
    end else begin
      rr_q <= rr_d;
    end
  end

endmodule

// File: rtl/fp_fma_arbiter.sv
// Shares one fixed-latency FMA unit among NUM_REQ requesters and routes results back.
// Latency: issue is combinational with the grant; result returns LATENCY cycles later.
// Backpressure: fma_ready_i low withholds all grants; requesters hold their requests.
//
// Ports:
//   clk_i, rst_ni           : clock, async active-low reset
//   req_i, opa/opb/opc_i,
//   op_i, rnd_i             : per-requester request and operation fields
//   gnt_o                   : one-hot grant, operation accepted in that cycle
//   rvalid_o, res_o,
//   status_o                : one-hot result pulse; result/status broadcast (zero when idle)
//   fma_*_o                 : issue side of the FMA unit (zero when no grant)
//   fma_res/status/valid_i,
//   fma_ready_i             : return side and readiness of the FMA unit
//   err_o                   : sticky flag, returned valid disagreed with the tracked tag
//   issue_cnt_o             : saturating count of granted operations
module fp_fma_arbiter
  import fp_fma_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ    = FPU_NUM_REQ,
  parameter int unsigned LATENCY    = 2,
  parameter int unsigned RND_WIDTH  = 2,
  parameter int unsigned STAT_WIDTH = 5
) (
  input  logic                               clk_i,
  input  logic                               rst_ni,
  input  logic [NUM_REQ-1:0]                 req_i,
  input  logic [NUM_REQ-1:0][31:0]           opa_i,
  input  logic [NUM_REQ-1:0][31:0]           opb_i,
  input  logic [NUM_REQ-1:0][31:0]           opc_i,
  input  logic [NUM_REQ-1:0][1:0]            op_i,
  input  logic [NUM_REQ-1:0][RND_WIDTH-1:0]  rnd_i,
  output logic [NUM_REQ-1:0]                 gnt_o,
  output logic [NUM_REQ-1:0]                 rvalid_o,
  output logic [31:0]                        res_o,
  output logic [STAT_WIDTH-1:0]              status_o,
  output logic                               fma_en_o,
  output logic [31:0]                        fma_opa_o,
  output logic [31:0]                        fma_opb_o,
  output logic [31:0]                        fma_opc_o,
  output logic [1:0]                         fma_op_o,
  output logic [RND_WIDTH-1:0]               fma_rnd_o,
  input  logic [31:0]                        fma_res_i,
  input  logic [STAT_WIDTH-1:0]              fma_status_i,
  input  logic                               fma_valid_i,
  input  logic                               fma_ready_i,
  output logic                               err_o,
  output logic [15:0]                        issue_cnt_o
);

  logic [ID_WIDTH-1:0] win_id;
  fma_tag_t            tag_q [LATENCY];
  fma_tag_t            tail;
  logic                err_q;
  logic [15:0]         cnt_q;

  rr_arb_tree_lite #(
    .NUM_REQ (NUM_REQ)
  ) u_arb (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .req_i  (req_i),
    .en_i   (fma_ready_i),
    .gnt_o  (gnt_o),
    .idx_o  (win_id)
  );

  assign fma_en_o = |gnt_o;

  // Issue mux: the winner's fields, forced to zero on idle cycles so the
  // FMA inputs never carry stale operands.
  always_comb begin
    fma_opa_o = '0;
    fma_opb_o = '0;
    fma_opc_o = '0;
    fma_op_o  = '0;
    fma_rnd_o = '0;
    if (fma_en_o) begin
      fma_opa_o = opa_i[win_id];
      fma_opb_o = opb_i[win_id];
      fma_opc_o = opc_i[win_id];
      fma_op_o  = op_i[win_id];
      fma_rnd_o = rnd_i[win_id];
    end
  end

  // Tag pipeline mirrors the FMA pipeline: it loads every cycle (idle cycles
  // load an invalid tag) and never stalls, so the tail lines up with the
  // result the unit presents LATENCY cycles after issue.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < LATENCY; i++) begin
        tag_q[i] <= '0;
      end
    end else begin
      tag_q[0] <= '{vld: fma_en_o, id: win_id};
      for (int unsigned i = 1; i < LATENCY; i++) begin
        tag_q[i] <= tag_q[i-1];
      end
    end
  end

  assign tail = tag_q[LATENCY-1];

  // Return path: only a valid result matched by a valid tag is delivered;
  // the broadcast buses stay zero otherwise.
  always_comb begin
    rvalid_o = '0;
    res_o    = '0;
    status_o = '0;
    if (fma_valid_i && tail.vld) begin
      rvalid_o[tail.id] = 1'b1;
      res_o             = fma_res_i;
      status_o          = fma_status_i;
    end
  end

  // A valid without a tag, or a tag without a valid, means the unit and the
  // tracker have lost step; latch it until reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      err_q <= 1'b0;
    end else if (fma_valid_i != tail.vld) begin
      err_q <= 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else if (fma_en_o && (cnt_q != 16'hFFFF)) begin
      cnt_q <= cnt_q + 16'd1;
    end
  end

  assign err_o       = err_q;
  assign issue_cnt_o = cnt_q;

endmodule

// File: tb/tb_fp_fma_arbiter.sv
// Self-checking bench for fp_fma_arbiter with an attached behavioural FMA unit.
// Latency: checks every cycle on the falling edge against a queue-based reference.
// Backpressure: exercises fma_ready_i stalls directed and at random.
module tb_fp_fma_arbiter;

  localparam int N = 4;
  localparam int L = 2;
  localparam int RW = 2;
  localparam int SW = 5;

  logic                    clk_i = 1'b0;
  logic                    rst_ni;
  logic [N-1:0]            req_i;
  logic [N-1:0][31:0]      opa_i, opb_i, opc_i;
  logic [N-1:0][1:0]       op_i;
  logic [N-1:0][RW-1:0]    rnd_i;
  logic [N-1:0]            gnt_o, rvalid_o;
  logic [31:0]             res_o;
  logic [SW-1:0]           status_o;
  logic                    fma_en_o;
  logic [31:0]             fma_opa_o, fma_opb_o, fma_opc_o;
  logic [1:0]              fma_op_o;
  logic [RW-1:0]           fma_rnd_o;
  logic [31:0]             fma_res_i;
  logic [SW-1:0]           fma_status_i;
  logic                    fma_valid_i;
  logic                    fma_ready_i;
  logic                    err_o;
  logic [15:0]             issue_cnt_o;
  logic                    inj_valid;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk_i = ~clk_i;

  fp_fma_arbiter #(.NUM_REQ(N), .LATENCY(L), .RND_WIDTH(RW), .STAT_WIDTH(SW)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .req_i(req_i),
    .opa_i(opa_i), .opb_i(opb_i), .opc_i(opc_i), .op_i(op_i), .rnd_i(rnd_i),
    .gnt_o(gnt_o), .rvalid_o(rvalid_o), .res_o(res_o), .status_o(status_o),
    .fma_en_o(fma_en_o), .fma_opa_o(fma_opa_o), .fma_opb_o(fma_opb_o),
    .fma_opc_o(fma_opc_o), .fma_op_o(fma_op_o), .fma_rnd_o(fma_rnd_o),
    .fma_res_i(fma_res_i), .fma_status_i(fma_status_i),
    .fma_valid_i(fma_valid_i), .fma_ready_i(fma_ready_i),
    .err_o(err_o), .issue_cnt_o(issue_cnt_o)
  );

  // ---------------- single-precision helpers (normals and zero) ----------------
  function automatic real sp2r(input logic [31:0] s);
    logic [63:0] d;
    if (s[30:0] == 31'd0) d = {s[31], 63'd0};
    else d = {s[31], 11'(s[30:23]) + 11'd896, s[22:0], 29'd0};
    return $bitstoreal(d);
  endfunction

  function automatic logic [31:0] r2sp(input real r);
    logic [63:0] d;
    logic [10:0] e;
    d = $realtobits(r);
    e = d[62:52];
    if (e < 11'd897) return {d[63], 31'd0};
    if (e > 11'd1150) return {d[63], 8'hFF, 23'd0};
    return {d[63], 8'(e - 11'd896), d[51:29]};
  endfunction

  // op[0] negates the product, op[1] negates the addend.
  function automatic logic [31:0] fma_fn(input logic [31:0] a, b, c, input logic [1:0] op);
    real p, q;
    p = sp2r(a) * sp2r(b);
    q = sp2r(c);
    if (op[0]) p = -p;
    if (op[1]) q = -q;
    return r2sp(p + q);
  endfunction

  function automatic logic [SW-1:0] st_fn(input logic [31:0] a, input logic [1:0] op,
                                          input logic [RW-1:0] rnd);
    return SW'({rnd, op, ^a});
  endfunction

  function automatic logic [31:0] rnd_sp();
    return {1'($urandom_range(0, 1)), 8'($urandom_range(124, 130)), 23'($urandom)};
  endfunction

  // ---------------- behavioural FMA unit, fixed latency L ----------------
  logic        pv [L];
  logic [31:0] pr [L];
  logic [SW-1:0] ps [L];

  always @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < L; i++) begin pv[i] <= 1'b0; pr[i] <= '0; ps[i] <= '0; end
    end else begin
      pv[0] <= fma_en_o;
      pr[0] <= fma_fn(fma_opa_o, fma_opb_o, fma_opc_o, fma_op_o);
      ps[0] <= st_fn(fma_opa_o, fma_op_o, fma_rnd_o);
      for (int i = 1; i < L; i++) begin pv[i] <= pv[i-1]; pr[i] <= pr[i-1]; ps[i] <= ps[i-1]; end
    end
  end

  assign fma_valid_i  = pv[L-1] | inj_valid;
  assign fma_res_i    = pv[L-1] ? pr[L-1] : 32'hDEADBEEF;
  assign fma_status_i = pv[L-1] ? ps[L-1] : '1;

  // ---------------- reference model ----------------
  typedef struct {
    int            due;
    int            id;
    logic [31:0]   res;
    logic [SW-1:0] st;
  } pend_t;

  pend_t q[$];
  int    m_rr  = 0;
  int    m_cnt = 0;
  bit    m_err = 1'b0;
  int    cyc_n = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%h expected=%h (cycle %0d)", tag, obs, exp, cyc_n);
    end
  endtask

  // Compare every output against the model for the current cycle, then
  // advance the model to the next cycle.
  task automatic sb();
    int w;
    int idx;
    bit due;
    logic [N-1:0] exp_rv;
    if (!rst_ni) begin
      chk("rst_gnt", 32'(gnt_o), 0);
      chk("rst_en", 32'(fma_en_o), 0);
      chk("rst_opa", fma_opa_o, 0);
      chk("rst_rvalid", 32'(rvalid_o), 0);
      chk("rst_res", res_o, 0);
      chk("rst_status", 32'(status_o), 0);
      chk("rst_err", 32'(err_o), 0);
      chk("rst_cnt", 32'(issue_cnt_o), 0);
      q.delete();
      m_rr = 0; m_cnt = 0; m_err = 1'b0;
    end else begin
      w = -1;
      if (fma_ready_i) begin
        for (int k = 0; k < N; k++) begin
          idx = (m_rr + k) % N;
          if (w < 0 && req_i[idx]) w = idx;
        end
      end
      chk("gnt", 32'(gnt_o), (w >= 0) ? (32'd1 << w) : 32'd0);
      chk("fma_en", 32'(fma_en_o), (w >= 0) ? 32'd1 : 32'd0);
      chk("fma_opa", fma_opa_o, (w >= 0) ? opa_i[w] : 32'd0);
      chk("fma_opb", fma_opb_o, (w >= 0) ? opb_i[w] : 32'd0);
      chk("fma_opc", fma_opc_o, (w >= 0) ? opc_i[w] : 32'd0);
      chk("fma_op_rnd", 32'({fma_op_o, fma_rnd_o}),
          (w >= 0) ? 32'({op_i[w], rnd_i[w]}) : 32'd0);
      due = (q.size() > 0) && (q[0].due == cyc_n);
      exp_rv = (due && fma_valid_i) ? N'(1 << q[0].id) : '0;
      chk("rvalid", 32'(rvalid_o), 32'(exp_rv));
      chk("res", res_o, (exp_rv != 0) ? q[0].res : 32'd0);
      chk("status", 32'(status_o), (exp_rv != 0) ? 32'(q[0].st) : 32'd0);
      chk("err", 32'(err_o), 32'(m_err));
      chk("issue_cnt", 32'(issue_cnt_o), 32'(m_cnt));
      if (fma_valid_i != due) m_err = 1'b1;
      if (due) void'(q.pop_front());
      if (w >= 0) begin
        q.push_back('{due: cyc_n + L, id: w,
                      res: fma_fn(opa_i[w], opb_i[w], opc_i[w], op_i[w]),
                      st: st_fn(opa_i[w], op_i[w], rnd_i[w])});
        m_rr = (w + 1) % N;
        if (m_cnt < 65535) m_cnt++;
      end
    end
    cyc_n++;
  endtask

  task automatic step();
    @(negedge clk_i);
    sb();
  endtask

  task automatic adv();
    @(posedge clk_i);
    #1;
  endtask

  task automatic rand_ops();
    for (int i = 0; i < N; i++) begin
      opa_i[i] = rnd_sp(); opb_i[i] = rnd_sp(); opc_i[i] = rnd_sp();
      op_i[i] = 2'($urandom); rnd_i[i] = RW'($urandom);
    end
  endtask

  task automatic do_reset();
    rst_ni = 1'b0; req_i = '0;
    step(); adv();
    rst_ni = 1'b1;
  endtask

  task automatic idle(input int n);
    req_i = '0;
    for (int i = 0; i < n; i++) begin step(); adv(); end
  endtask

  initial begin
    rst_ni = 1'b0; req_i = '0; fma_ready_i = 1'b1; inj_valid = 1'b0;
    opa_i = '0; opb_i = '0; opc_i = '0; op_i = '0; rnd_i = '0;

    // Reset state
    step(); adv();
    rst_ni = 1'b1;

    // Single requester, three back-to-back grants, results on cycles 2..4
    for (int k = 0; k < 6; k++) begin
      req_i = (k < 3) ? 4'b0010 : 4'b0000;
      rand_ops();
      step();
      if (k < 3) chk("single_gnt", 32'(gnt_o), 32'h2);
      chk("single_rvalid", 32'(rvalid_o), (k >= 2 && k <= 4) ? 32'h2 : 32'h0);
      adv();
    end
    step(); chk("single_cnt", 32'(issue_cnt_o), 3); adv();

    // Fairness from a fresh pointer: 0,1,2,3,0
    do_reset();
    req_i = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      rand_ops();
      step(); chk("fair_gnt", 32'(gnt_o), 32'd1 << (k % 4)); adv();
    end
    idle(3);

    // Stall: no grant while not ready, requester 0 first on release
    do_reset();
    fma_ready_i = 1'b0; req_i = 4'b0101;
    for (int k = 0; k < 2; k++) begin
      step(); chk("stall_gnt", 32'(gnt_o), 0); chk("stall_en", 32'(fma_en_o), 0); adv();
    end
    fma_ready_i = 1'b1;
    step(); chk("release_gnt", 32'(gnt_o), 32'h1); adv();
    idle(3);

    // Result routing: 3.0*2.0+1.0 from requester 2
    req_i = 4'b0100;
    opa_i[2] = 32'h40400000; opb_i[2] = 32'h40000000; opc_i[2] = 32'h3F800000;
    op_i[2] = 2'b00; rnd_i[2] = '0;
    step(); chk("route_gnt", 32'(gnt_o), 32'h4); adv();
    req_i = '0;
    step(); adv();
    step(); chk("route_rvalid", 32'(rvalid_o), 32'h4); chk("route_res", res_o, 32'h40E00000); adv();
    idle(2);

    // Spurious valid with nothing in flight
    inj_valid = 1'b1;
    step(); chk("spur_rvalid", 32'(rvalid_o), 0); chk("spur_res", res_o, 0); adv();
    inj_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin step(); chk("spur_err_sticky", 32'(err_o), 1); adv(); end
    do_reset();
    step(); chk("spur_err_cleared", 32'(err_o), 0); adv();

    // Reset one cycle after a grant: the operation must never return
    req_i = 4'b0001; rand_ops();
    step(); adv();
    req_i = '0; rst_ni = 1'b0;
    step(); adv();
    rst_ni = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      chk("mid_rvalid", 32'(rvalid_o), 0); chk("mid_res", res_o, 0);
      chk("mid_err", 32'(err_o), 0); chk("mid_cnt", 32'(issue_cnt_o), 0);
      adv();
    end

    // Random traffic with random stalls
    for (int k = 0; k < 400; k++) begin
      req_i = N'($urandom);
      fma_ready_i = ($urandom_range(0, 3) != 0);
      rand_ops();
      step(); adv();
    end
    fma_ready_i = 1'b1;
    idle(L + 2);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
